i2c_slave: RTL

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with a 7-bit address; SCL and SDA are sampled on clk
// and never used as clocks. SDA is open-drain (drives only 0 or Z).
// Ports: clk, rst (synchronous, active-high); scl in, sda inout;
//   tx_data in / rd_req out  : read side (byte presented on rd_req);
//   rx_data / rx_valid out   : write side (last byte from the master);
//   busy, done out           : addressed-transaction status.
// Build option: define I2C_SLAVE_FILTER_EN to add a 3-sample stability
// filter on scl and sda ahead of edge detection.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_req,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA,
        WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic scl_d, sda_d;
    logic scl_q, sda_q, scl_p_q, sda_p_q;

`ifdef I2C_SLAVE_FILTER_EN
    logic [2:0] scl_h_q, sda_h_q;

    // The filtered level only moves once 3 raw samples agree.
    always_comb begin
        scl_d = scl_q;
        sda_d = sda_q;
        if (&scl_h_q)       scl_d = 1'b1;
        else if (~|scl_h_q) scl_d = 1'b0;
        if (&sda_h_q)       sda_d = 1'b1;
        else if (~|sda_h_q) sda_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_h_q <= 3'b111;
            sda_h_q <= 3'b111;
        end else begin
            scl_h_q <= {scl_h_q[1:0], scl};
            sda_h_q <= {sda_h_q[1:0], sda};
        end
    end
`else
    assign scl_d = scl;
    assign sda_d = sda;
`endif

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_q & ~scl_p_q;
    assign scl_fall  = ~scl_q & scl_p_q;
    assign start_det = scl_q & sda_p_q & ~sda_q;
    assign stop_det  = scl_q & ~sda_p_q & sda_q;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       oe_q, oe_d;
    logic       pend_q, pend_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rd_req_q, rd_req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] shin;

    assign shin = {shift_q[6:0], sda_q};

    // pend_q marks "byte complete, move on at the next SCL fall".
    // tx_q holds the bits still to send, next one in tx_q[7].
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rx_data_d  = rx_data_q;
        oe_d       = oe_q;
        pend_d     = pend_q;
        rx_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
            done_d  = busy_q;
        end else if (start_det) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (pend_q) begin
                        if (scl_fall) begin
                            state_d = ADDR_ACK;
                            oe_d    = 1'b1;
                            pend_d  = 1'b0;
                        end
                    end else if (scl_rise) begin
                        shift_d = shin;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (shin[7:1] == SLAVE_ADDR) begin
                                busy_d   = 1'b1;
                                pend_d   = 1'b1;
                                rd_req_d = shin[0];
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift_q[0]) begin
                            tx_d    = {tx_data[6:0], 1'b0};
                            oe_d    = ~tx_data[7];
                            state_d = RD_DATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (pend_q) begin
                        if (scl_fall) begin
                            state_d = WR_ACK;
                            oe_d    = 1'b1;
                            pend_d  = 1'b0;
                        end
                    end else if (scl_rise) begin
                        shift_d = shin;
                        if (cnt_q == 4'd7) begin
                            cnt_d      = 4'd0;
                            rx_data_d  = shin;
                            rx_valid_d = 1'b1;
                            pend_d     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            oe_d    = 1'b0;
                            state_d = RD_ACK;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                            oe_d  = ~tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (pend_q) begin
                        if (scl_fall) begin
                            tx_d    = {tx_data[6:0], 1'b0};
                            oe_d    = ~tx_data[7];
                            pend_d  = 1'b0;
                            state_d = RD_DATA;
                        end
                    end else if (scl_rise) begin
                        if (!sda_q) begin
                            rd_req_d = 1'b1;
                            pend_d   = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            rx_data_q  <= 8'h00;
            oe_q       <= 1'b0;
            pend_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            scl_p_q    <= scl_q;
            sda_p_q    <= sda_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rx_data_q  <= rx_data_d;
            oe_q       <= oe_d;
            pend_q     <= pend_d;
            rx_valid_q <= rx_valid_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rd_req   = rd_req_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
